// File: rtl/hs_bridge_pkg.sv
// rtl/hs_bridge_pkg.sv - shared types, width constants and index helper for the hs_bridge arbiter
package hs_bridge_pkg;

  localparam int BRIDGE_WIDTH  = 8;
  localparam int ARB_N_SRC     = 4;
  localparam int ARB_MAX_BURST = 4;

  typedef enum logic [0:0] {S_ARB, S_GRANT} arb_state_t;

  // (a + b) mod n for a, b < n; avoids a divider in the wrap logic
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned n);
    int unsigned s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - first set request at or after ptr, searching upward with wrap
module rr_pick
  import hs_bridge_pkg::*;
#(
  parameter int  N_SRC = ARB_N_SRC,
  localparam int IW    = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             found,
  output logic [IW-1:0]    idx
);

  int unsigned j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      j = wrap_add(32'(ptr), k, N_SRC);
      if (!found && req[j[IW-1:0]]) begin
        found = 1'b1;
        idx   = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/hs_bridge_arb.sv
// rtl/hs_bridge_arb.sv - round-robin burst arbiter feeding one registered hs_bridge input port
module hs_bridge_arb
  import hs_bridge_pkg::*;
#(
  parameter int  N_SRC     = ARB_N_SRC,
  parameter int  WIDTH     = BRIDGE_WIDTH,
  parameter int  MAX_BURST = ARB_MAX_BURST,
  localparam int IW        = $clog2(N_SRC),
  localparam int BW        = $clog2(MAX_BURST + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic [N_SRC-1:0]       src_valid,
  output logic [N_SRC-1:0]       src_ready,
  output logic [WIDTH-1:0]       dst_data,
  output logic                   dst_valid,
  input  logic                   dst_ready,
  output logic [IW-1:0]          grant_id,
  output logic                   busy
);

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             dvalid_q, dvalid_d;
  logic [WIDTH-1:0] ddata_q, ddata_d;

  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic             in_grant;
  logic             gnt_valid;
  logic             gnt_ready;
  logic [WIDTH-1:0] gnt_data;
  logic             accept;
  logic             last_beat;
  logic             release_gnt;
  int unsigned      next_ptr;

  rr_pick #(.N_SRC(N_SRC)) u_pick (
    .req   (src_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign in_grant  = (state_q == S_GRANT);
  assign gnt_valid = src_valid[gnt_q];
  assign gnt_data  = src_data[gnt_q*WIDTH +: WIDTH];
  // Output register can take a new beat when empty or being drained this cycle
  assign gnt_ready = !dvalid_q || dst_ready;
  assign accept    = in_grant && gnt_valid && gnt_ready;
  assign last_beat = (beat_q == BW'(MAX_BURST - 1));
  assign release_gnt = in_grant && ((accept && last_beat) || !gnt_valid);
  assign next_ptr  = wrap_add(32'(gnt_q), 1, N_SRC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_ARB;
      gnt_q    <= '0;
      ptr_q    <= '0;
      beat_q   <= '0;
      dvalid_q <= 1'b0;
      ddata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      beat_q   <= beat_d;
      dvalid_q <= dvalid_d;
      ddata_q  <= ddata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    beat_d   = beat_q;
    dvalid_d = dvalid_q;
    ddata_d  = ddata_q;
    case (state_q)
      S_ARB: begin
        if (pick_found) begin
          gnt_d   = pick_idx;
          beat_d  = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (release_gnt) begin
          state_d = S_ARB;
          ptr_d   = next_ptr[IW-1:0];
        end
      end
      default: state_d = S_ARB;
    endcase
    if (accept) begin
      ddata_d  = gnt_data;
      dvalid_d = 1'b1;
      beat_d   = beat_q + BW'(1);
    end else if (dst_ready) begin
      dvalid_d = 1'b0;
    end
  end

  always_comb begin
    src_ready = '0;
    busy      = in_grant;
    if (in_grant) begin
      src_ready[gnt_q] = gnt_ready;
    end
  end

  assign dst_data  = ddata_q;
  assign dst_valid = dvalid_q;
  assign grant_id  = gnt_q;

endmodule

// File: tb/tb_hs_bridge_arb.sv
// tb/tb_hs_bridge_arb.sv - scoreboard bench for hs_bridge_arb with directed source traffic
module tb_hs_bridge_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_valid;
  logic [N-1:0]   src_ready;
  logic [W-1:0]   dst_data;
  logic           dst_valid;
  logic           dst_ready;
  logic [1:0]     grant_id;
  logic           busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] srcq [N][$];
  logic [7:0] expq [$];
  logic [1:0] glog [$];
  logic       busy_prev = 1'b0;

  always #5 clk = ~clk;

  hs_bridge_arb #(.N_SRC(N), .WIDTH(W), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .dst_data  (dst_data),
    .dst_valid (dst_valid),
    .dst_ready (dst_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Sources: present queue head, advance only after a handshake at the edge
  initial begin
    logic [N-1:0] fire;
    src_valid = '0;
    src_data  = '0;
    forever begin
      @(negedge clk);
      fire = src_valid & src_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fire[i]) void'(srcq[i].pop_front());
        src_valid[i] = (srcq[i].size() > 0);
        src_data[i*W +: W] = (srcq[i].size() > 0) ? srcq[i][0] : 8'h00;
      end
    end
  end

  // Monitor: score every beat the bridge takes and log each new grant
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && dst_valid && dst_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dst_extra: got beat %02h required none", dst_data);
        end else begin
          e = expq.pop_front();
          chk("dst_data", 32'(dst_data), 32'(e));
        end
      end
      if (busy && !busy_prev) glog.push_back(grant_id);
      busy_prev = busy;
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_dst_valid"}, 32'(dst_valid), 32'd0);
    chk({tag, "_src_ready"}, 32'(src_ready), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_grant_id"},  32'(grant_id),  32'd0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("rst_idle");
    chk("rst_dst_data", 32'(dst_data), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    glog.delete();
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int  n;
    logic empty;
    n = 0;
    forever begin
      empty = (expq.size() == 0);
      for (int i = 0; i < N; i++) if (srcq[i].size() != 0) empty = 1'b0;
      if ((empty && !busy && !dst_valid) || n >= 300) break;
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      fail_now({tag, "_drain"});
      expq.delete();
      for (int i = 0; i < N; i++) srcq[i].delete();
    end
  endtask

  // ids packs grant k in bits [2k+1:2k]
  task automatic check_log(input string tag, input int n, input logic [9:0] ids);
    chk({tag, "_len"}, 32'(glog.size()), 32'(n));
    for (int i = 0; i < n && i < glog.size(); i++)
      chk({tag, "_gnt"}, 32'(glog[i]), 32'(ids[2*i +: 2]));
    glog.delete();
  endtask

  task automatic wait_for_valid(input string tag, input logic use_data, input logic [7:0] d);
    int n;
    n = 0;
    while (!(dst_valid && (!use_data || dst_data == d)) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    dst_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("rst_init");
    chk("rst_init_dst_data", 32'(dst_data), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    dst_ready = 1'b1;

    // Single source, back-to-back, first beat two cycles after valid
    @(negedge clk);
    srcq[2].push_back(8'h11); srcq[2].push_back(8'h22); srcq[2].push_back(8'h33);
    expq.push_back(8'h11); expq.push_back(8'h22); expq.push_back(8'h33);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_first_valid", 32'(dst_valid), 32'd1);
    chk("t1_first_data",  32'(dst_data),  32'h11);
    chk("t1_grant_id",    32'(grant_id),  32'd2);
    chk("t1_src_ready",   32'(src_ready), 32'b0100);
    chk("t1_busy",        32'(busy),      32'd1);
    drain("t1");
    check_log("t1", 1, {2'd0, 2'd0, 2'd0, 2'd0, 2'd2});

    // Two streaming sources alternate in bursts of four
    for (int k = 1; k <= 8; k++) begin
      srcq[0].push_back(8'(k));
      srcq[1].push_back(8'(8'h10 + k));
    end
    for (int k = 1; k <= 4; k++) expq.push_back(8'(k));
    for (int k = 1; k <= 4; k++) expq.push_back(8'(8'h10 + k));
    for (int k = 5; k <= 8; k++) expq.push_back(8'(k));
    for (int k = 5; k <= 8; k++) expq.push_back(8'(8'h10 + k));
    drain("t2");
    check_log("t2", 4, {2'd0, 2'd1, 2'd0, 2'd1, 2'd0});

    // All four sources: grant order 0,1,2,3 then wrap to 0
    apply_reset();
    for (int k = 1; k <= 5; k++) srcq[0].push_back(8'(k));
    srcq[1].push_back(8'h11); srcq[2].push_back(8'h21); srcq[3].push_back(8'h31);
    for (int k = 1; k <= 4; k++) expq.push_back(8'(k));
    expq.push_back(8'h11); expq.push_back(8'h21); expq.push_back(8'h31); expq.push_back(8'h05);
    drain("t3");
    check_log("t3", 5, {2'd0, 2'd3, 2'd2, 2'd1, 2'd0});

    // Backpressure for five cycles mid-burst
    for (int k = 1; k <= 4; k++) begin
      srcq[1].push_back(8'(8'hA0 + k));
      expq.push_back(8'(8'hA0 + k));
    end
    wait_for_valid("t4_wait_a2", 1'b1, 8'hA2);
    @(posedge clk);
    #1 dst_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_stall_data",  32'(dst_data),  32'hA3);
      chk("t4_stall_valid", 32'(dst_valid), 32'd1);
      chk("t4_stall_ready", 32'(src_ready), 32'd0);
    end
    @(posedge clk);
    #1 dst_ready = 1'b1;
    drain("t4");
    check_log("t4", 1, {2'd0, 2'd0, 2'd0, 2'd0, 2'd1});

    // Early release: src 1 goes idle after two beats, src 3 gets a full burst
    apply_reset();
    srcq[1].push_back(8'hB1); srcq[1].push_back(8'hB2);
    for (int k = 1; k <= 4; k++) srcq[3].push_back(8'(8'hD0 + k));
    expq.push_back(8'hB1); expq.push_back(8'hB2);
    for (int k = 1; k <= 4; k++) expq.push_back(8'(8'hD0 + k));
    drain("t5");
    check_log("t5", 2, {2'd0, 2'd0, 2'd0, 2'd3, 2'd1});

    // Async reset while a beat sits in the output register
    dst_ready = 1'b0;
    for (int k = 1; k <= 4; k++) srcq[2].push_back(8'(8'hE0 + k));
    srcq[3].push_back(8'hF1);
    expq.push_back(8'hE2); expq.push_back(8'hE3); expq.push_back(8'hE4); expq.push_back(8'hF1);
    wait_for_valid("t6_wait_valid", 1'b0, 8'h00);
    chk("t6_held_data", 32'(dst_data), 32'hE1);
    #2 rst = 1'b1;
    #1;
    check_reset("t6_async");
    @(posedge clk);
    #1 rst = 1'b0;
    dst_ready = 1'b1;
    drain("t6");
    check_log("t6", 3, {2'd0, 2'd0, 2'd3, 2'd2, 2'd2});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hs_bridge_arb.md
# hs_bridge_arb

Round-robin stream arbiter that shares one `hs_bridge` input port among `N_SRC` valid/ready producers. It grants one source at a time, holds the grant for a bounded burst, and drives a registered output stage straight into the bridge's `data_in`/`valid`/`ready` port. Bursts from a source are never interleaved, and a source can never be starved.

## Interface
- `N_SRC`, default 4: number of requesters; must be ≥2.
- `WIDTH`, default 8: data width; matches the bridge `WIDTH`.
- `MAX_BURST`, default 4: maximum beats per grant; must be ≥1.
- `clk` in, 1: clock; all logic is on the rising edge.
- `rst` in, 1: reset, asynchronous and active-high.
- `src_data` in, `N_SRC*WIDTH`: source i occupies bits `[i*WIDTH +: WIDTH]`.
- `src_valid` in, `N_SRC`: per-source valid.
- `src_ready` out, `N_SRC`: per-source ready.
- `dst_data` out, `WIDTH`: connects to bridge `data_in`.
- `dst_valid` out, 1: connects to bridge `valid`.
- `dst_ready` in, 1: connects from bridge `ready`.
- `grant_id` out, `$clog2(N_SRC)`: index of the current or last granted source.
- `busy` out, 1: high while in `S_GRANT`.

## Operation
- States: `S_ARB` and `S_GRANT`. Registers:
  - `state`
  - `gnt` (`$clog2(N_SRC)` bits)
  - `ptr` (`$clog2(N_SRC)` bits; the next-priority source)
  - `beat_cnt` (`$clog2(MAX_BURST+1)` bits)
  - `dst_valid`
  - `dst_data`
- Reset values:
  - `state=S_ARB`; `ptr`, `gnt`, `beat_cnt` = 0.
  - `dst_valid=0`, `dst_data=0`, `busy=0`, `grant_id=0`, `src_ready` all 0.
- `S_ARB`:
  - All `src_ready` are low.
  - If any `src_valid` is high, pick the first source with valid set, searching from `ptr` upward with wrap modulo `N_SRC`.
  - Load `gnt` with that index, clear `beat_cnt`, and go to `S_GRANT`.
  - If no source is valid, stay in `S_ARB`.
- `S_GRANT`:
  - `src_ready[gnt] = !dst_valid || dst_ready`. All other `src_ready` are 0.
  - Accept = `src_valid[gnt] && src_ready[gnt]`. On accept: `dst_data <= src_data[gnt]`, `dst_valid <= 1`, `beat_cnt++`.
  - Release, i.e. next state `S_ARB` with `ptr <= (gnt+1) mod N_SRC`, when either:
    - an accept occurs with `beat_cnt == MAX_BURST-1` (burst limit reached), or
    - `src_valid[gnt]` is low (source idle; no accept that cycle).
  - Both release conditions are evaluated on the same edge.
- Output stage:
  - `dst_valid` clears when `dst_ready` is high and no accept occurs that cycle.
  - While `dst_valid && !dst_ready`, `dst_data` and `dst_valid` hold stable.
- `grant_id` = `gnt` register. `busy` = (`state == S_GRANT`).
- Source protocol: a source must not drop valid or change data while stalled. If it does, the block treats low valid as the end of the burst.
- `MAX_BURST=1`: release after every beat, giving strict per-beat round-robin.
- Pointer wrap: after granting source `N_SRC-1`, `ptr` becomes 0.
- Reset mid-burst: any beat held in the output register is discarded and the grant is dropped. The arbiter restarts at source 0.

## Timing
- Arbitration latency: `src_valid` rising in `S_ARB` at cycle t gives `src_ready` high at t+1.
- Data latency: a beat accepted at cycle t appears on `dst_data`/`dst_valid` at t+1.
- Throughput:
  - One beat per cycle inside a grant when `dst_ready` is held high.
  - One dead cycle (`S_ARB`) between consecutive grants.
- `src_ready` depends combinationally on `dst_ready`, `dst_valid` and `state`/`gnt` only. It never depends on `src_valid`.

## Structure
- Shared package `hs_bridge_pkg`: `typedef enum logic [0:0] {S_ARB, S_GRANT} arb_state_t`. Bridge-level width constants also live here.
- One sub-module, `rr_pick`: combinational, inputs `req[N_SRC]` and `ptr`, outputs `found` and `idx` (first set bit at or after `ptr`, with wrap).
- The top-level FSM, beat counter and output register live in `hs_bridge_arb`.

## Test plan
- Single source: src 2 sends 0x11,0x22,0x33 back-to-back with `dst_ready=1` → `dst_data` shows 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after the first valid; `grant_id=2`.
- Burst limit: src 0 and src 1 both stream continuously with `MAX_BURST=4` → output is 4 beats from src 0, one gap cycle, 4 beats from src 1, gap, then src 0 again.
- Round-robin wrap: all 4 sources valid → grant order 0,1,2,3,0; `ptr` wraps from 3 to 0.
- Backpressure: hold `dst_ready=0` for 5 cycles mid-burst → `dst_data` stays stable, `src_ready[gnt]=0`, and no beat is lost or duplicated once ready returns.
- Early release: src 1 sends 2 beats then drops valid while src 3 is valid → grant moves to 3 after one `S_ARB` cycle; `beat_cnt` restarts at 0.
- Async reset asserted mid-burst with `dst_valid=1` → `dst_valid`, `src_ready` and `busy` go to 0 immediately; after release, the first grant goes to the lowest valid source at or after 0.
